// File: rtl/mem_dma_master.sv
// Bus-master DMA: copies cfg_len words src->dst, one read then one write per word, with a per-access watchdog.
// Optional fill mode (write cfg_pattern, no reads) is enabled by defining MEM_DMA_FILL_EN.
`timescale 1ns/1ps
module mem_dma_master #(
  parameter int WDT_CYCLES = 1024,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [26:0]      cfg_src,
  input  logic [26:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_go,
  input  logic             cfg_abort,
`ifdef MEM_DMA_FILL_EN
  input  logic             cfg_fill,
  input  logic [31:0]      cfg_pattern,
`endif
  output logic             dma_busy,
  output logic             dma_done,
  output logic             dma_error,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [26:0]      bus_addr,
  output logic [31:0]      bus_data,
  output logic             bus_we,
  output logic             bus_start,
  input  logic             bus_busy,
  input  logic [31:0]      bus_q
);

  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, REQ, RD_ISSUE, RD_ACK, RD_DONE, WR_ISSUE, WR_ACK, WR_DONE, FINISH
  } state_t;

  state_t           state_reg, state_next;
  logic [26:0]      src_reg, src_next, dst_reg, dst_next, addr_reg, addr_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [31:0]      buf_reg, buf_next, data_reg, data_next;
  logic [WDT_W-1:0] wdt_reg, wdt_next;
  logic             we_reg, we_next, start_reg, start_next, req_reg, req_next;
  logic             busy_reg, busy_next, done_reg, done_next, error_reg, error_next;
  logic             fill_mode;
  logic [31:0]      fill_word;
  logic             in_access, access_ends;

`ifdef MEM_DMA_FILL_EN
  logic        fill_reg;
  logic [31:0] pattern_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_reg    <= 1'b0;
      pattern_reg <= 32'h0;
    end else if (state_reg == IDLE && cfg_go) begin
      fill_reg    <= cfg_fill;
      pattern_reg <= cfg_pattern;
    end
  end

  assign fill_mode = fill_reg;
  assign fill_word = pattern_reg;
`else
  assign fill_mode = 1'b0;
  assign fill_word = 32'h0;
`endif

  assign in_access   = (state_reg == RD_ACK) || (state_reg == RD_DONE) ||
                       (state_reg == WR_ACK) || (state_reg == WR_DONE);
  assign access_ends = ((state_reg == RD_DONE) || (state_reg == WR_DONE)) && !bus_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      buf_reg   <= '0;
      data_reg  <= '0;
      wdt_reg   <= '0;
      we_reg    <= 1'b0;
      start_reg <= 1'b0;
      req_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      buf_reg   <= buf_next;
      data_reg  <= data_next;
      wdt_reg   <= wdt_next;
      we_reg    <= we_next;
      start_reg <= start_next;
      req_reg   <= req_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      error_reg <= error_next;
    end
  end

  // Bus outputs are registered, so each *_ISSUE state lands its drive values on the edge leaving it.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    buf_next   = buf_reg;
    data_next  = data_reg;
    wdt_next   = wdt_reg;
    we_next    = we_reg;
    start_next = start_reg;
    req_next   = req_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    error_next = error_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_go) begin
          src_next   = cfg_src;
          dst_next   = cfg_dst;
          len_next   = cfg_len;
          error_next = 1'b0;
          busy_next  = 1'b1;
          if (cfg_len == '0) begin
            state_next = FINISH;
          end else begin
            req_next   = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (bus_gnt) state_next = fill_mode ? WR_ISSUE : RD_ISSUE;
      end
      RD_ISSUE: begin
        addr_next  = src_reg;
        we_next    = 1'b0;
        start_next = 1'b1;
        wdt_next   = '0;
        state_next = RD_ACK;
      end
      RD_ACK: begin
        if (bus_busy) state_next = RD_DONE;
      end
      RD_DONE: begin
        if (!bus_busy) begin
          buf_next   = bus_q;
          start_next = 1'b0;
          state_next = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        addr_next  = dst_reg;
        data_next  = fill_mode ? fill_word : buf_reg;
        we_next    = 1'b1;
        start_next = 1'b1;
        wdt_next   = '0;
        state_next = WR_ACK;
      end
      WR_ACK: begin
        if (bus_busy) state_next = WR_DONE;
      end
      WR_DONE: begin
        if (!bus_busy) begin
          start_next = 1'b0;
          we_next    = 1'b0;
          if (!fill_mode) src_next = src_reg + 27'd1;
          dst_next = dst_reg + 27'd1;
          len_next = len_reg - LEN_W'(1);
          if (len_reg == LEN_W'(1) || cfg_abort) state_next = FINISH;
          else                                   state_next = fill_mode ? WR_ISSUE : RD_ISSUE;
        end
      end
      FINISH: begin
        req_next   = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Watchdog overrides the access states: an access that never completes ends the job with an error.
    if (in_access && !access_ends) begin
      wdt_next = wdt_reg + WDT_W'(1);
      if (wdt_reg == WDT_LAST) begin
        start_next = 1'b0;
        we_next    = 1'b0;
        error_next = 1'b1;
        state_next = FINISH;
      end
    end
  end

  assign dma_busy  = busy_reg;
  assign dma_done  = done_reg;
  assign dma_error = error_reg;
  assign bus_req   = req_reg;
  assign bus_addr  = addr_reg;
  assign bus_data  = data_reg;
  assign bus_we    = we_reg;
  assign bus_start = start_reg;

endmodule
